// File: rtl/output_pkg.sv
// Shared definitions for the bit-entry / bit-display units.
package output_pkg;

  typedef enum logic {
    IDLE,
    SHOW
  } state_t;

  localparam int WIDTH_DEFAULT = 8;

  // Width of a bit index into a WIDTH-bit value; never below one bit.
  function automatic int idx_w(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/output_unit_if.sv
// Value handshake and display signals between the controller (master) and output_unit (slave).
interface output_unit_if
  import output_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
);
  localparam int IDX_W = idx_w(WIDTH);

  logic [WIDTH-1:0] value_in;
  logic             value_valid;
  logic             value_taken;
  logic             bit_out;
  logic [IDX_W-1:0] bit_idx;
  logic             busy;
  logic             done;

  modport master (
    output value_in, value_valid,
    input  value_taken, bit_out, bit_idx, busy, done
  );

  modport slave (
    input  value_in, value_valid,
    output value_taken, bit_out, bit_idx, busy, done
  );

endinterface

// File: rtl/output_unit_edge_rise.sv
// One-bit rising-edge detector; the delay flop tracks its input every cycle.
module edge_rise (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic prev_d;
  logic prev_q;

  assign prev_d = d;

  always_ff @(posedge clk) begin
    if (rst) prev_q <= 1'b0;
    else     prev_q <= prev_d;
  end

  assign rise = d & ~prev_q;

endmodule

// File: rtl/output_unit.sv
// Plays an accepted WIDTH-bit value back MSB first on bit_out, one bit per button
// rise (and optionally per timer period), pulsing done after the last bit.
module output_unit
  import output_pkg::*;
#(
  parameter int WIDTH       = WIDTH_DEFAULT,
  parameter bit AUTO_STEP   = 1'b0,
  parameter int STEP_CYCLES = 50_000_000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  input  logic         btn_next,
  output_unit_if.slave ou
);

  localparam int IDX_W = idx_w(WIDTH);
  localparam int TMR_W = $clog2(STEP_CYCLES);
  localparam logic [IDX_W-1:0] IDX_TOP    = IDX_W'(WIDTH - 1);
  localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(STEP_CYCLES - 1);

  state_t           state_q,   state_d;
  logic [WIDTH-1:0] shreg_q,   shreg_d;
  logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
  logic [TMR_W-1:0] timer_q,   timer_d;
  logic             bit_out_q, bit_out_d;
  logic             busy_q,    busy_d;
  logic             taken_q,   taken_d;
  logic             done_q,    done_d;

  logic next_rise;
  logic step;

  edge_rise u_next_rise (
    .clk  (clk),
    .rst  (rst),
    .d    (btn_next),
    .rise (next_rise)
  );

  // A button rise and a timer expiry in the same cycle collapse into one advance.
  assign step = next_rise | (AUTO_STEP && (timer_q == '0));

  always_comb begin
    // NOTE: every _d starts from a default so no branch can leave one unassigned and infer a latch.
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_idx_d = bit_idx_q;
    timer_d   = timer_q;
    bit_out_d = bit_out_q;
    busy_d    = busy_q;
    taken_d   = 1'b0;
    done_d    = 1'b0;

    if (!enable) begin
      state_d   = IDLE;
      shreg_d   = '0;
      bit_idx_d = '0;
      timer_d   = '0;
      bit_out_d = 1'b0;
      busy_d    = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          busy_d    = 1'b0;
          bit_out_d = 1'b0;
          bit_idx_d = '0;
          if (ou.value_valid) begin
            state_d   = SHOW;
            shreg_d   = ou.value_in;
            bit_idx_d = IDX_TOP;
            timer_d   = TMR_RELOAD;
            taken_d   = 1'b1;
            busy_d    = 1'b1;
            bit_out_d = ou.value_in[WIDTH-1];
          end
        end
        SHOW: begin
          busy_d = 1'b1;
          if (step && (bit_idx_q != '0)) begin
            shreg_d   = shreg_q << 1;
            bit_idx_d = bit_idx_q - 1'b1;
            timer_d   = TMR_RELOAD;
          end else if (step) begin
            state_d   = IDLE;
            shreg_d   = '0;
            bit_idx_d = '0;
            done_d    = 1'b1;
            busy_d    = 1'b0;
          end else if (AUTO_STEP) begin
            timer_d = timer_q - 1'b1;
          end
          bit_out_d = (state_d == SHOW) ? shreg_d[WIDTH-1] : 1'b0;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: the shift register is plain flops, so it is cleared on reset like the rest of the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_idx_q <= '0;
      timer_q   <= '0;
      bit_out_q <= 1'b0;
      busy_q    <= 1'b0;
      taken_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      // NOTE: sequential state uses <= so every flop samples pre-edge values.
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_idx_q <= bit_idx_d;
      timer_q   <= timer_d;
      bit_out_q <= bit_out_d;
      busy_q    <= busy_d;
      taken_q   <= taken_d;
      done_q    <= done_d;
    end
  end

  assign ou.bit_out     = bit_out_q;
  assign ou.bit_idx     = bit_idx_q;
  assign ou.busy        = busy_q;
  assign ou.value_taken = taken_q;
  assign ou.done        = done_q;

endmodule

// File: doc/output_unit.md
Name: output_unit

Overview:
- Return-path counterpart of the button-driven bit-entry unit: accepts an 8-bit value with a valid strobe and plays it back one bit at a time, MSB first, on a single bit output (LED).
- Advances one bit per rising edge of btn_next, or automatically on a timer when AUTO_STEP=1.
- Pulses done after the last bit, so the top-level controller can sequence result display after value entry.

Parameters:
- WIDTH, 8, bits per value; bit index width IDX_W = $clog2(WIDTH).
- AUTO_STEP, 0, 1 = also advance automatically every STEP_CYCLES clocks; 0 = button only.
- STEP_CYCLES, 50_000_000, auto-advance period in clk cycles; must be >= 2.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- enable  input  1  block active; low forces return to IDLE.
- value_in  input  WIDTH  value to display; sampled only on acceptance.
- value_valid  input  1  request to display value_in.
- btn_next  input  1  advance button, level; already debounced and synchronised upstream.
- bit_out  output  1  bit currently shown.
- bit_idx  output  IDX_W  index of the bit shown (WIDTH-1 down to 0).
- busy  output  1  high while a value is being shown.
- value_taken  output  1  one-cycle pulse: value_in accepted.
- done  output  1  one-cycle pulse: last bit advanced past.

Behaviour:
- Reset (synchronous, rst high at posedge): state=IDLE; bit_out=0, bit_idx=0, busy=0, value_taken=0, done=0; shift register, step timer and btn_next delay flop cleared.
- Edge detect: next_rise = btn_next & ~btn_next_q. The flop updates every cycle regardless of enable, so a button held across acceptance produces no rise.
- IDLE:
  - busy=0, bit_out=0, bit_idx=0.
  - On enable & value_valid at posedge: shreg<=value_in, bit_idx<=WIDTH-1, timer<=STEP_CYCLES-1, state<=SHOW.
  - Same edge: value_taken=1, busy=1, bit_out=value_in[WIDTH-1]. Acceptance latency is 1 cycle.
- SHOW:
  - bit_out=shreg[WIDTH-1], busy=1.
  - Define step = next_rise | (AUTO_STEP & timer==0).
  - On step with bit_idx>0: shreg<=shreg<<1, bit_idx<=bit_idx-1, timer reload.
  - On step with bit_idx==0: state<=IDLE; done=1 for exactly one cycle; busy=0, bit_out=0 on the same edge.
  - Otherwise, if AUTO_STEP, the timer decrements.
- Simultaneous events:
  - next_rise and timer expiry in the same cycle: a single advance.
  - value_valid while busy: ignored, not queued, no value_taken.
  - next_rise in IDLE: ignored.
  - value_valid and next_rise in the same IDLE cycle: accept only; the press is not applied to the new value.
- enable low:
  - Dominates everything. Next posedge goes to IDLE and clears outputs as in reset.
  - No done pulse; value_taken is suppressed.
- rst mid-SHOW: abort with no done; state identical to power-on.
- value_taken and done are never high in the same cycle.
- value_in is don't-care outside the acceptance cycle.

Decomposition:
- Shared package output_pkg holds:
  - state enum {IDLE, SHOW};
  - WIDTH_DEFAULT=8;
  - the IDX_W helper.
- The input unit may adopt the same package later.
- One natural sub-module: edge_rise (1-bit rising-edge detector with synchronous reset), reusable for the button inputs elsewhere.

Test Plan:
- Basic playback: value_in=8'b1011_0010, value_valid 1 cycle, then 8 btn_next presses (3-cycle pulses, gaps). Expect:
  - value_taken at acceptance;
  - bit_out sequence 1,0,1,1,0,0,1,0 with bit_idx 7..0;
  - done exactly once, on the 8th press edge;
  - busy low afterwards.
- Held button: btn_next already high at acceptance of 8'hFF and held 20 cycles. Expect bit_idx stays 7 until release and re-press.
- Busy rejection: value_valid with 8'h0F during SHOW at bit_idx=4. Expect:
  - no value_taken;
  - playback continues with the original value;
  - a fresh 8'h0F is accepted only after done.
- Abort: enable dropped at bit_idx=3. Expect IDLE next cycle, busy=0, no done. rst asserted mid-SHOW gives the same result.
- Auto-step (AUTO_STEP=1, STEP_CYCLES=4): value 8'hA5, no button. Expect:
  - one advance every 4 cycles;
  - done 32 cycles after acceptance;
  - a btn_next rise coincident with expiry causes a single advance.
